arb_requester: RTL

Initiator side of the req/gnt arbitration handshake used by the `statemachine` arbiter. It queues transfer commands, raises `req`, waits for `gnt`, and counts granted beats. When the burst completes it drops `req` and waits for `gnt` to fall before issuing the next command. Two instances drive `req_0` and `req_1` of one arbiter.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/req_cmd_fifo.sv | 58 +++++
 rtl/arb_requester.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared definitions for the arbitration requester: one-hot
//               FSM state encoding and default sizing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Default sizing for the requester and its command queue
  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

  // One-hot requester states; RELEASE extends the original 3-bit set to 4 bits
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_REQ     = 4'b0010,
    ST_GRANT   = 4'b0100,
    ST_RELEASE = 4'b1000
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/req_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : req_cmd_fifo
// Description : Synchronous FIFO holding burst-length commands. Pointers carry
//               one wrap bit so full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module req_cmd_fifo
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = LEN_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents are never observed while empty, so no reset
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Read/write pointer advance; reset empties the queue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : arb_requester
// Description : Initiator side of the req/gnt arbitration handshake. Queues
//               burst commands, requests the bus, counts granted beats,
//               abandons a request after TIMEOUT ungranted cycles and waits
//               for the grant to fall before the next command.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LEN_W-1:0]  fifo_data;

  req_cmd_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (cmd_valid),
    .push_data_i (cmd_len),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign cmd_ready  = !fifo_full;
  assign req        = req_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign beat_valid = (state_q == ST_GRANT) && gnt;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  // Next-state, counters and pulse generation for the handshake FSM
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_data == '0) begin
            // Zero-length command completes without touching the arbiter
            done_d = 1'b1;
          end else begin
            remaining_d = fifo_data;
            wait_cnt_d  = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (gnt) begin
          state_d = ST_GRANT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d   = 1'b1;
          remaining_d = '0;
          state_d     = ST_RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_GRANT: begin
        if (gnt) begin
          // remaining is at least 1 here, so the decrement cannot wrap
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_RELEASE;
          end
        end else begin
          // Grant withdrawn mid-burst: keep requesting with a fresh timeout
          wait_cnt_d = '0;
          state_d    = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (!gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ) || (state_d == ST_GRANT);
  end

  // State and output registers; reset drops req without waiting for a clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule
`default_nettype wire
